// File: rtl/control_unit_pkg.sv
// Shared types and encodings for the multicycle RV64 control unit.
// The ALU function codes here must match the datapath ALU decoder.
package control_pkg;

   typedef enum logic [3:0] {
      S_FETCH      = 4'd0,
      S_FETCH_WAIT = 4'd1,
      S_DECODE     = 4'd2,
      S_MEM_ADDR   = 4'd3,
      S_MEM_READ   = 4'd4,
      S_MEM_WAIT   = 4'd5,
      S_MEM_WB     = 4'd6,
      S_MEM_WRITE  = 4'd7,
      S_EXEC_R     = 4'd8,
      S_EXEC_I     = 4'd9,
      S_ALU_WB     = 4'd10,
      S_BRANCH     = 4'd11,
      S_PC_INC     = 4'd12,
      S_HALT       = 4'd13
   } state_t;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_XOR   = 4'b0011;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_PASSB = 4'b1000;

   localparam logic [1:0] SRCB_REG  = 2'd0;
   localparam logic [1:0] SRCB_FOUR = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;
   localparam logic [1:0] SRCB_IMM2 = 2'd3;

   localparam logic [1:0] SPLICE_LD  = 2'b00;
   localparam logic [1:0] SPLICE_LW  = 2'b01;
   localparam logic [1:0] SPLICE_LH  = 2'b10;
   localparam logic [1:0] SPLICE_LBU = 2'b11;

   typedef enum logic [1:0] {
      CLS_R     = 2'd0,
      CLS_IMM   = 2'd1,
      CLS_LUI   = 2'd2,
      CLS_OTHER = 2'd3
   } op_class_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_op;
      logic       load_a_out;
      logic       reg_write;
      logic       load_reg_a;
      logic       load_reg_b;
      logic       mem_to_reg;
      logic       dmem_op;
      logic       load_mdr;
      logic       imem_read;
      logic       ir_write;
      logic [1:0] load_splice;
      logic       halted;
   } ctrl_t;

   function automatic logic load_f3_legal(input logic [2:0] f3);
      return (f3 == 3'b011) || (f3 == 3'b010) || (f3 == 3'b001) || (f3 == 3'b100);
   endfunction

   function automatic logic [1:0] splice_of(input logic [2:0] f3);
      logic [1:0] s;
      s = SPLICE_LD;
      case (f3)
         3'b010:  s = SPLICE_LW;
         3'b001:  s = SPLICE_LH;
         3'b100:  s = SPLICE_LBU;
         default: s = SPLICE_LD;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/control_unit_alu_control.sv
// Maps opcode class and funct fields to an ALU function code.
// Flags encodings outside the supported subset as illegal.
module alu_control
   import control_pkg::*;
(
   input  op_class_t  op_class,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] alu_op,
   output logic       illegal
);

   always_comb begin
      alu_op  = ALU_ADD;
      illegal = 1'b0;
      case (op_class)
         CLS_R: begin
            case (funct3)
               3'b000:  alu_op = funct7_5 ? ALU_SUB : ALU_ADD;
               3'b111:  begin alu_op = ALU_AND; illegal = funct7_5; end
               3'b110:  begin alu_op = ALU_OR;  illegal = funct7_5; end
               3'b100:  begin alu_op = ALU_XOR; illegal = funct7_5; end
               3'b010:  begin alu_op = ALU_SLT; illegal = funct7_5; end
               default: illegal = 1'b1;
            endcase
         end
         // For op-imm the funct7 position is immediate data, so it is ignored.
         CLS_IMM: begin
            case (funct3)
               3'b000:  alu_op = ALU_ADD;
               3'b111:  alu_op = ALU_AND;
               3'b110:  alu_op = ALU_OR;
               3'b100:  alu_op = ALU_XOR;
               default: illegal = 1'b1;
            endcase
         end
         CLS_LUI: alu_op = ALU_PASSB;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multicycle Moore control FSM for the RV64 datapath: sequences fetch,
// decode, execute, memory and write-back, and drives every datapath flag.
module control_unit
   import control_pkg::*;
#(
   parameter int unsigned HALT_ON_ILLEGAL = 1,
   parameter int unsigned ALU_OP_W        = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         instruction,
   input  logic                alu_zero,
   output logic                PCWrite,
   output logic                PCWriteCond,
   output logic                PCSource,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [ALU_OP_W-1:0] ALUOp,
   output logic                LoadAOut,
   output logic                RegWrite,
   output logic                LoadRegA,
   output logic                LoadRegB,
   output logic                MemToReg,
   output logic                DMemOp,
   output logic                LoadMDR,
   output logic                IMemRead,
   output logic                IRWrite,
   output logic [1:0]          LoadSplice,
   output logic                halted,
   output logic [3:0]          state_out
);

   localparam state_t ILLEGAL_NEXT = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_PC_INC;

   state_t     state_q, state_d;
   ctrl_t      ctrl, ctrl_o;
   op_class_t  op_class;
   logic [3:0] dec_alu_op;
   logic       dec_illegal;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_instr_bits;

   assign opcode            = instruction[6:0];
   assign funct3            = instruction[14:12];
   assign unused_instr_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

   always_comb begin
      case (opcode)
         OPC_R:   op_class = CLS_R;
         OPC_IMM: op_class = CLS_IMM;
         OPC_LUI: op_class = CLS_LUI;
         default: op_class = CLS_OTHER;
      endcase
   end

   alu_control u_alu_control (
      .op_class (op_class),
      .funct3   (funct3),
      .funct7_5 (instruction[30]),
      .alu_op   (dec_alu_op),
      .illegal  (dec_illegal)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      ctrl    = '0;
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            ctrl.imem_read = 1'b1;
            state_d        = S_FETCH_WAIT;
         end
         S_FETCH_WAIT: begin
            ctrl.ir_write = 1'b1;
            state_d       = S_DECODE;
         end
         // ALUOut captures PC + imm*2 here so a taken branch can use it.
         S_DECODE: begin
            ctrl.load_reg_a = 1'b1;
            ctrl.load_reg_b = 1'b1;
            ctrl.alu_src_b  = SRCB_IMM2;
            ctrl.alu_op     = ALU_ADD;
            ctrl.load_a_out = 1'b1;
            case (opcode)
               OPC_R:            state_d = dec_illegal ? ILLEGAL_NEXT : S_EXEC_R;
               OPC_IMM, OPC_LUI: state_d = dec_illegal ? ILLEGAL_NEXT : S_EXEC_I;
               OPC_LOAD:         state_d = load_f3_legal(funct3) ? S_MEM_ADDR : ILLEGAL_NEXT;
               OPC_STORE:        state_d = (funct3 == 3'b011) ? S_MEM_ADDR : ILLEGAL_NEXT;
               OPC_BRANCH:       state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : ILLEGAL_NEXT;
               OPC_SYSTEM:       state_d = S_HALT;
               default:          state_d = ILLEGAL_NEXT;
            endcase
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_IMM;
            ctrl.alu_op     = ALU_ADD;
            ctrl.load_a_out = 1'b1;
            state_d         = (opcode == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: state_d = S_MEM_WAIT;
         S_MEM_WAIT: begin
            ctrl.load_mdr = 1'b1;
            state_d       = S_MEM_WB;
         end
         S_MEM_WB: begin
            ctrl.mem_to_reg  = 1'b1;
            ctrl.reg_write   = 1'b1;
            ctrl.load_splice = splice_of(funct3);
            state_d          = S_PC_INC;
         end
         S_MEM_WRITE: begin
            ctrl.dmem_op = 1'b1;
            state_d      = S_PC_INC;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_REG;
            ctrl.alu_op     = dec_alu_op;
            ctrl.load_a_out = 1'b1;
            state_d         = S_ALU_WB;
         end
         S_EXEC_I: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_IMM;
            ctrl.alu_op     = dec_alu_op;
            ctrl.load_a_out = 1'b1;
            state_d         = S_ALU_WB;
         end
         S_ALU_WB: begin
            ctrl.reg_write = 1'b1;
            state_d        = S_PC_INC;
         end
         // beq lets the datapath gate on zero; bne needs the inverted flag here.
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_source = 1'b1;
            if (funct3 == 3'b000) begin
               ctrl.pc_write_cond = 1'b1;
               state_d            = alu_zero ? S_FETCH : S_PC_INC;
            end else begin
               ctrl.pc_write = !alu_zero;
               state_d       = alu_zero ? S_PC_INC : S_FETCH;
            end
         end
         S_PC_INC: begin
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_write  = 1'b1;
            state_d        = S_FETCH;
         end
         S_HALT: ctrl.halted = 1'b1;
         default: state_d = S_FETCH;
      endcase
   end

   // While reset is held every flag is forced low so nothing is written.
   assign ctrl_o = reset ? ctrl : '0;

   assign PCWrite     = ctrl_o.pc_write;
   assign PCWriteCond = ctrl_o.pc_write_cond;
   assign PCSource    = ctrl_o.pc_source;
   assign ALUSrcA     = ctrl_o.alu_src_a;
   assign ALUSrcB     = ctrl_o.alu_src_b;
   assign ALUOp       = ALU_OP_W'(ctrl_o.alu_op);
   assign LoadAOut    = ctrl_o.load_a_out;
   assign RegWrite    = ctrl_o.reg_write;
   assign LoadRegA    = ctrl_o.load_reg_a;
   assign LoadRegB    = ctrl_o.load_reg_b;
   assign MemToReg    = ctrl_o.mem_to_reg;
   assign DMemOp      = ctrl_o.dmem_op;
   assign LoadMDR     = ctrl_o.load_mdr;
   assign IMemRead    = ctrl_o.imem_read;
   assign IRWrite     = ctrl_o.ir_write;
   assign LoadSplice  = ctrl_o.load_splice;
   assign halted      = ctrl_o.halted;
   assign state_out   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle expected control vectors are queued by
// the driver and compared by a negedge monitor.
module tb_control_unit;

   localparam int W = 26;

   localparam logic [3:0] ST_F = 4'd0, ST_FW = 4'd1, ST_D = 4'd2, ST_MA = 4'd3;
   localparam logic [3:0] ST_MR = 4'd4, ST_MWT = 4'd5, ST_MWB = 4'd6, ST_MWR = 4'd7;
   localparam logic [3:0] ST_ER = 4'd8, ST_EI = 4'd9, ST_AWB = 4'd10, ST_BR = 4'd11;
   localparam logic [3:0] ST_PCI = 4'd12, ST_H = 4'd13, ST_RST = 4'd15;

   localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_XOR = 4'b0011;
   localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111, A_PASSB = 4'b1000;

   localparam logic [W-1:0] X_PW  = 26'd1 << 16;
   localparam logic [W-1:0] X_PWC = 26'd1 << 15;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction;
   logic        alu_zero;
   logic [31:0] nop_instr;

   logic       pc_write, pc_write_cond, pc_source, alu_src_a, load_a_out, reg_write;
   logic       load_reg_a, load_reg_b, mem_to_reg, dmem_op, load_mdr, imem_read, ir_write, halted;
   logic [1:0] alu_src_b, load_splice;
   logic [3:0] alu_op, state_out;

   logic       n_pc_write, n_pc_write_cond, n_pc_source, n_alu_src_a, n_load_a_out, n_reg_write;
   logic       n_load_reg_a, n_load_reg_b, n_mem_to_reg, n_dmem_op, n_load_mdr, n_imem_read;
   logic       n_ir_write, n_halted;
   logic [1:0] n_alu_src_b, n_load_splice;
   logic [3:0] n_alu_op, n_state_out;

   logic [W-1:0] obs, obs2;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp2_q[$];
   int           tag_q[$];
   int           checks, errors, tag;

   always #5 clk = ~clk;

   control_unit u_dut (
      .clk(clk), .reset(reset), .instruction(instruction), .alu_zero(alu_zero),
      .PCWrite(pc_write), .PCWriteCond(pc_write_cond), .PCSource(pc_source),
      .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ALUOp(alu_op), .LoadAOut(load_a_out),
      .RegWrite(reg_write), .LoadRegA(load_reg_a), .LoadRegB(load_reg_b),
      .MemToReg(mem_to_reg), .DMemOp(dmem_op), .LoadMDR(load_mdr), .IMemRead(imem_read),
      .IRWrite(ir_write), .LoadSplice(load_splice), .halted(halted), .state_out(state_out)
   );

   control_unit #(.HALT_ON_ILLEGAL(0), .ALU_OP_W(4)) u_nop (
      .clk(clk), .reset(reset), .instruction(nop_instr), .alu_zero(1'b0),
      .PCWrite(n_pc_write), .PCWriteCond(n_pc_write_cond), .PCSource(n_pc_source),
      .ALUSrcA(n_alu_src_a), .ALUSrcB(n_alu_src_b), .ALUOp(n_alu_op), .LoadAOut(n_load_a_out),
      .RegWrite(n_reg_write), .LoadRegA(n_load_reg_a), .LoadRegB(n_load_reg_b),
      .MemToReg(n_mem_to_reg), .DMemOp(n_dmem_op), .LoadMDR(n_load_mdr), .IMemRead(n_imem_read),
      .IRWrite(n_ir_write), .LoadSplice(n_load_splice), .halted(n_halted), .state_out(n_state_out)
   );

   assign obs = {state_out, imem_read, ir_write, load_reg_a, load_reg_b, reg_write, pc_write,
                 pc_write_cond, pc_source, dmem_op, load_mdr, mem_to_reg, halted,
                 alu_src_b, load_splice, alu_op, alu_src_a, load_a_out};
   assign obs2 = {n_state_out, n_imem_read, n_ir_write, n_load_reg_a, n_load_reg_b, n_reg_write,
                  n_pc_write, n_pc_write_cond, n_pc_source, n_dmem_op, n_load_mdr, n_mem_to_reg,
                  n_halted, n_alu_src_b, n_load_splice, n_alu_op, n_alu_src_a, n_load_a_out};

   // Per-state flags that do not depend on the instruction.
   function automatic logic [W-1:0] base(input logic [3:0] st);
      logic [W-1:0] v;
      v = '0;
      if (st == ST_RST) return v;
      v[25:22] = st;
      case (st)
         ST_F:   v[21] = 1'b1;
         ST_FW:  v[20] = 1'b1;
         ST_D:   begin v[19] = 1'b1; v[18] = 1'b1; v[9:8] = 2'd3; v[5:2] = A_ADD; v[0] = 1'b1; end
         ST_MA:  begin v[1] = 1'b1; v[9:8] = 2'd2; v[5:2] = A_ADD; v[0] = 1'b1; end
         ST_MWT: v[12] = 1'b1;
         ST_MWB: begin v[11] = 1'b1; v[17] = 1'b1; end
         ST_MWR: v[13] = 1'b1;
         ST_ER:  begin v[1] = 1'b1; v[0] = 1'b1; end
         ST_EI:  begin v[1] = 1'b1; v[9:8] = 2'd2; v[0] = 1'b1; end
         ST_AWB: v[17] = 1'b1;
         ST_BR:  begin v[1] = 1'b1; v[5:2] = A_SUB; v[14] = 1'b1; end
         ST_PCI: begin v[9:8] = 2'd1; v[5:2] = A_ADD; v[16] = 1'b1; end
         ST_H:   v[10] = 1'b1;
         default: v = v;
      endcase
      return v;
   endfunction

   function automatic logic [W-1:0] op_f(input logic [3:0] op);
      return W'(op) << 2;
   endfunction

   function automatic logic [W-1:0] spl_f(input logic [1:0] s);
      return W'(s) << 6;
   endfunction

   task automatic push(input logic [3:0] st, input logic [W-1:0] extra);
      exp_q.push_back(base(st) | extra);
      tag_q.push_back(tag);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, got, want);
      end
   endtask

   task automatic monitor();
      logic [W-1:0] e;
      int t;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (obs !== e) begin
               errors++;
               $display("FAIL step instr%0d got %h expected %h", t, obs, e);
            end
         end
         if (exp2_q.size() != 0) begin
            e = exp2_q.pop_front();
            checks++;
            if (obs2 !== e) begin
               errors++;
               $display("FAIL nop_dut got %h expected %h", obs2, e);
            end
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 64) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout instr%0d pending %0d", tag, exp_q.size());
         exp_q.delete();
         tag_q.delete();
      end
      #1;
   endtask

   task automatic fd(input logic [31:0] ins, input logic z);
      instruction = ins;
      alu_zero    = z;
      tag++;
      push(ST_F, '0);
      push(ST_FW, '0);
      push(ST_D, '0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      push(ST_RST, '0);
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic run_r(input logic [31:0] ins, input logic [3:0] op, input logic is_r);
      fd(ins, 1'b0);
      push(is_r ? ST_ER : ST_EI, op_f(op));
      push(ST_AWB, '0);
      push(ST_PCI, '0);
      drain();
   endtask

   task automatic run_load(input logic [31:0] ins, input logic [1:0] s);
      fd(ins, 1'b0);
      push(ST_MA, '0);
      push(ST_MR, '0);
      push(ST_MWT, '0);
      push(ST_MWB, spl_f(s));
      push(ST_PCI, '0);
      drain();
   endtask

   task automatic run_halt(input logic [31:0] ins);
      fd(ins, 1'b0);
      push(ST_H, '0);
      push(ST_H, '0);
      push(ST_H, '0);
      drain();
      do_reset();
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      tag         = 0;
      reset       = 1'b0;
      instruction = 32'h0;
      alu_zero    = 1'b0;
      nop_instr   = 32'h0000007F;
      fork
         monitor();
      join_none
      push(ST_RST, '0);
      exp2_q.push_back(base(ST_RST));
      for (int i = 0; i < 2; i++) begin
         exp2_q.push_back(base(ST_F));
         exp2_q.push_back(base(ST_FW));
         exp2_q.push_back(base(ST_D));
         exp2_q.push_back(base(ST_PCI));
      end
      @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;

      run_r(32'h002081B3, A_ADD, 1'b1);
      run_r(32'h402081B3, A_SUB, 1'b1);
      run_r(32'h0020A1B3, A_SLT, 1'b1);
      run_r(32'h0020F1B3, A_AND, 1'b1);
      run_r(32'h0020E1B3, A_OR, 1'b1);
      run_r(32'hFFF00093, A_ADD, 1'b0);
      run_r(32'h0FF0C093, A_XOR, 1'b0);
      run_r(32'h123452B7, A_PASSB, 1'b0);

      run_load(32'h0080B283, 2'b00);
      run_load(32'h0000A283, 2'b01);
      run_load(32'h00009283, 2'b10);
      run_load(32'h0000C283, 2'b11);

      fd(32'h0020B823, 1'b0);
      push(ST_MA, '0);
      push(ST_MWR, '0);
      push(ST_PCI, '0);
      drain();

      fd(32'h00208063, 1'b1);
      push(ST_BR, X_PWC);
      drain();
      fd(32'h00208063, 1'b0);
      push(ST_BR, X_PWC);
      push(ST_PCI, '0);
      drain();
      fd(32'h00209063, 1'b0);
      push(ST_BR, X_PW);
      drain();
      fd(32'h00209063, 1'b1);
      push(ST_BR, '0);
      push(ST_PCI, '0);
      drain();

      run_halt(32'h0000007F);
      run_halt(32'h4020F1B3);
      run_halt(32'h0000F283);
      run_halt(32'h0020A823);
      run_halt(32'h0020A063);
      run_halt(32'h00000073);

      fd(32'h0020B823, 1'b0);
      push(ST_MA, '0);
      drain();
      chk("dmem_before_reset", {31'd0, dmem_op}, 32'd1);
      reset = 1'b0;
      #1;
      chk("dmem_async_reset", {31'd0, dmem_op}, 32'd0);
      chk("state_async_reset", {28'd0, state_out}, 32'd0);
      push(ST_RST, '0);
      @(posedge clk);
      #1 reset = 1'b1;
      run_r(32'h002081B3, A_ADD, 1'b1);

      if (exp2_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL nop_dut_pending %0d", exp2_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle Moore FSM that drives every control flag of the RV64 multicycle datapath (`processing`).
- Consumes the datapath's instruction-register output and ALU zero flag; produces PC, ALU, regfile, data-memory and instruction-memory controls.
- Subset: R-type add/sub/and/or/xor/slt; I-type addi/andi/ori/xori; loads ld/lw/lh/lbu; store sd; beq/bne; lui; ebreak/ecall halt.

Parameters:
- HALT_ON_ILLEGAL, 1, 1 = illegal encoding goes to HALT; 0 = treated as NOP (goes straight to PC_INC).
- ALU_OP_W, 4, width of ALUOp.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- instruction  in  32  IR contents; valid from DECODE onward, stable until next IRWrite.
- alu_zero  in  1  ALU zero flag, combinational from the datapath.
- PCWrite, PCWriteCond, PCSource  out  1 each  PC control; PCSource 0 = alu_res, 1 = ALUOut.
- ALUSrcA  out  1  0 = PC, 1 = reg A.
- ALUSrcB  out  2  0 = reg B, 1 = const 4, 2 = imm, 3 = imm*2.
- ALUOp  out  ALU_OP_W  ALU function code (package constants).
- LoadAOut, RegWrite, LoadRegA, LoadRegB, MemToReg, DMemOp, LoadMDR, IMemRead, IRWrite  out  1 each.
- LoadSplice  out  2  00 ld, 01 lw (sign-extend), 10 lh (sign-extend), 11 lbu (zero-extend).
- halted  out  1  high in HALT.
- state_out  out  4  current state encoding, for debug.

Behaviour:
- Clock and reset: single clock `clk`; `reset` is asynchronous and active-low. Reset low forces state to FETCH and gates all outputs to 0. After release, FETCH outputs apply from the first cycle.
- Outputs are Moore: decoded from state plus instruction fields. Branch PC writes also use alu_zero combinationally. Any flag not listed for a state is 0.
- States, encoded 0..13 in this order:
  - FETCH: IMemRead=1 -> FETCH_WAIT.
  - FETCH_WAIT: IRWrite=1 -> DECODE. Synchronous instruction memory, 1-cycle read latency. PC is not advanced here.
  - DECODE: LoadRegA=1, LoadRegB=1, ALUSrcA=0, ALUSrcB=3, ALUOp=ADD, LoadAOut=1, so ALUOut = old PC + imm*2 (branch target). Dispatch on opcode:
    - 0110011 -> EXEC_R
    - 0010011 or 0110111 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - 1110011 -> HALT
    - else illegal.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD, LoadAOut=1 -> MEM_READ for loads, MEM_WRITE for stores.
  - MEM_READ: DMemOp=0 -> MEM_WAIT.
  - MEM_WAIT: LoadMDR=1 -> MEM_WB.
  - MEM_WB: MemToReg=1, RegWrite=1, LoadSplice from funct3 (011->00, 010->01, 001->10, 100->11) -> PC_INC.
  - MEM_WRITE: DMemOp=1 -> PC_INC.
  - EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp from the funct map, LoadAOut=1 -> ALU_WB.
  - EXEC_I: ALUSrcA=1, ALUSrcB=2, LoadAOut=1 -> ALU_WB. ALUOp from funct3 for op-imm; PASSB for lui.
  - ALU_WB: MemToReg=0, RegWrite=1 -> PC_INC.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSource=1.
    - beq: PCWriteCond=1.
    - bne: PCWrite = !alu_zero.
    - Taken -> FETCH; not taken -> PC_INC.
  - PC_INC: ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0, PCWrite=1 -> FETCH.
  - HALT: all flags 0, halted=1. Exit only by reset.
- Funct map:
  - funct3 000 with funct7[5]=0 -> ADD; with funct7[5]=1 (R-type only) -> SUB.
  - 111 -> AND; 110 -> OR; 100 -> XOR; 010 (R-type only) -> SLT.
  - Any other funct3/funct7 combination is illegal.
- Illegal cases, handled per HALT_ON_ILLEGAL: load funct3 not in {011, 010, 001, 100}; store funct3 != 011; branch funct3 not in {000, 001}.
- Instruction latencies:
  - R-type, I-type, lui, store: 6 cycles.
  - Load: 8 cycles.
  - Branch: 4 cycles taken, 5 not taken.
- Reset mid-instruction: the partial instruction is abandoned and nothing is written in the reset cycle.

Decomposition:
- Shared package control_pkg:
  - state_t enum.
  - Opcode constants.
  - ALU codes: AND=0000, OR=0001, ADD=0010, XOR=0011, SUB=0110, SLT=0111, PASSB=1000. The datapath ALU must decode these same codes.
  - ALUSrcB select constants.
  - LoadSplice codes.
- One sub-module, alu_control: combinational map of (opcode class, funct3, funct7[5]) to ALUOp plus an illegal flag.

Test Plan:
- add x3,x1,x2 (0x002081B3) after reset -> states 0,1,2,8,10,12,0; RegWrite pulses once in cycle 5; PCWrite once in cycle 6 with ALUSrcB=1.
- ld x5,8(x1) -> MEM_READ DMemOp=0, LoadMDR in MEM_WAIT, MEM_WB with LoadSplice=00 and MemToReg=1; 8 cycles total.
- beq, once with alu_zero=1 and once with alu_zero=0:
  - alu_zero=1: PCWriteCond=1 and PCSource=1 in BRANCH, next state FETCH (4 cycles).
  - alu_zero=0: PC_INC follows (5 cycles).
- bne with alu_zero=0 -> PCWrite=1 in BRANCH; with alu_zero=1 -> PCWrite=0, then PC_INC.
- Illegal opcode 0x0000007F -> HALT, halted=1, no RegWrite/DMemOp. With HALT_ON_ILLEGAL=0 it goes DECODE -> PC_INC instead.
- Reset driven low during MEM_WRITE -> DMemOp drops to 0 immediately (asynchronous); after release state_out=0 and IMemRead=1.
